// File: rtl/ball_if.sv
// Signal bundle between the pong ball controller and the movers, paddles and score display.
// master is the controller side; slave is the surrounding game logic.
interface ball_if #(
    parameter int CWIDTH = 9
);
    logic              start;
    logic [CWIDTH:0]   ball_x;
    logic [CWIDTH:0]   ball_y;
    logic [CWIDTH:0]   left_paddle_y;
    logic [CWIDTH:0]   right_paddle_y;
    logic              move_active;
    logic              x_direction;
    logic              y_direction;
    logic [63:0]       threshold;
    logic [3:0]        score_left;
    logic [3:0]        score_right;
    logic              point_pulse;
    logic              game_over;

    modport master (
        input  start, ball_x, ball_y, left_paddle_y, right_paddle_y,
        output move_active, x_direction, y_direction, threshold,
               score_left, score_right, point_pulse, game_over
    );

    modport slave (
        output start, ball_x, ball_y, left_paddle_y, right_paddle_y,
        input  move_active, x_direction, y_direction, threshold,
               score_left, score_right, point_pulse, game_over
    );
endinterface

// File: rtl/ball_controller.sv
// Pong ball sequencer: serve delay, wall/paddle bounces with speed-up, scoring and game over.
// Every output is a register; the next value of each is computed in one combinational block.
module ball_controller #(
    parameter int CWIDTH         = 9,
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int PADDLE_H       = 64,
    parameter int BASE_THRESHOLD = 200000,
    parameter int THRESHOLD_STEP = 10000,
    parameter int MIN_THRESHOLD  = 50000,
    parameter int SERVE_DELAY    = 50000000,
    parameter int WIN_SCORE      = 7
) (
    input  logic   clock,
    input  logic   reset,
    ball_if.master bus
);
    typedef enum logic [2:0] {IDLE, SERVE, PLAY, SCORED, OVER} state_t;

    localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [CNT_W-1:0]  SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
    localparam logic [CWIDTH:0]   X_LEFT_PAD = (CWIDTH+1)'(1);
    localparam logic [CWIDTH:0]   X_RIGHT_PAD = (CWIDTH+1)'(SCREEN_W - 2);
    localparam logic [CWIDTH:0]   X_RIGHT_GOAL = (CWIDTH+1)'(SCREEN_W - 1);
    localparam logic [CWIDTH:0]   Y_BOTTOM = (CWIDTH+1)'(SCREEN_H - 1);
    localparam logic [CWIDTH+1:0] PAD_SPAN = (CWIDTH+2)'(PADDLE_H - 1);
    localparam logic [63:0]       BASE = 64'(BASE_THRESHOLD);
    localparam logic [63:0]       STEP = 64'(THRESHOLD_STEP);
    localparam logic [63:0]       FLOOR = 64'(MIN_THRESHOLD);
    localparam logic [3:0]        WIN = 4'(WIN_SCORE);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             move_q, move_next;
    logic             xdir_q, xdir_next;
    logic             ydir_q, ydir_next;
    logic [63:0]      thr_q, thr_next, thr_fast;
    logic [3:0]       sl_q, sl_next, sr_q, sr_next;
    logic             pulse_q, pulse_next;
    logic             over_q, over_next;

    // Paddle range tests one bit wider than the coordinates so paddle_y + span cannot wrap.
    logic [CWIDTH+1:0] by_w, lp_w, rp_w;
    logic              in_left, in_right;
    logic              left_goal, right_goal;

    assign by_w     = {1'b0, bus.ball_y};
    assign lp_w     = {1'b0, bus.left_paddle_y};
    assign rp_w     = {1'b0, bus.right_paddle_y};
    assign in_left  = (by_w >= lp_w) && (by_w <= lp_w + PAD_SPAN);
    assign in_right = (by_w >= rp_w) && (by_w <= rp_w + PAD_SPAN);

    // Ball at x=0 moving left is a point for the right player, and vice versa.
    assign right_goal = (bus.ball_x == '0) && !xdir_q;
    assign left_goal  = (bus.ball_x == X_RIGHT_GOAL) && xdir_q;

    // Comparing before subtracting keeps the speed-up from underflowing below the floor.
    assign thr_fast = (thr_q >= FLOOR + STEP) ? thr_q - STEP : FLOOR;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_next = state;
        cnt_next   = cnt;
        move_next  = 1'b0;
        xdir_next  = xdir_q;
        ydir_next  = ydir_q;
        thr_next   = thr_q;
        sl_next    = sl_q;
        sr_next    = sr_q;
        pulse_next = 1'b0;
        over_next  = 1'b0;

        case (state)
            IDLE, OVER: begin
                over_next = (state == OVER);
                if (bus.start) begin
                    state_next = SERVE;
                    cnt_next   = '0;
                    sl_next    = '0;
                    sr_next    = '0;
                    thr_next   = BASE;
                    over_next  = 1'b0;
                end
            end
            SERVE: begin
                if (cnt == SERVE_LAST) begin
                    state_next = PLAY;
                    cnt_next   = '0;
                    move_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PLAY: begin
                move_next = 1'b1;
                if (right_goal || left_goal) begin
                    // Scoring wins over any wall flip in the same cycle.
                    move_next  = 1'b0;
                    pulse_next = 1'b1;
                    state_next = SCORED;
                    if (right_goal && sr_q != WIN) sr_next = sr_q + 4'd1;
                    if (left_goal && sl_q != WIN)  sl_next = sl_q + 4'd1;
                end else begin
                    if (bus.ball_y == '0 && !ydir_q)      ydir_next = 1'b1;
                    if (bus.ball_y == Y_BOTTOM && ydir_q) ydir_next = 1'b0;
                    if (bus.ball_x == X_LEFT_PAD && !xdir_q && in_left) begin
                        xdir_next = 1'b1;
                        thr_next  = thr_fast;
                    end
                    if (bus.ball_x == X_RIGHT_PAD && xdir_q && in_right) begin
                        xdir_next = 1'b0;
                        thr_next  = thr_fast;
                    end
                end
            end
            SCORED: begin
                // x_direction already points at the conceding player, so it is simply held.
                thr_next  = BASE;
                ydir_next = !ydir_q;
                cnt_next  = '0;
                if (sl_q == WIN || sr_q == WIN) begin
                    state_next = OVER;
                    over_next  = 1'b1;
                end else begin
                    state_next = SERVE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            move_q  <= 1'b0;
            xdir_q  <= 1'b1;
            ydir_q  <= 1'b1;
            thr_q   <= BASE;
            sl_q    <= '0;
            sr_q    <= '0;
            pulse_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state   <= state_next;
            cnt     <= cnt_next;
            move_q  <= move_next;
            xdir_q  <= xdir_next;
            ydir_q  <= ydir_next;
            thr_q   <= thr_next;
            sl_q    <= sl_next;
            sr_q    <= sr_next;
            pulse_q <= pulse_next;
            over_q  <= over_next;
        end
    end

    assign bus.move_active = move_q;
    assign bus.x_direction = xdir_q;
    assign bus.y_direction = ydir_q;
    assign bus.threshold   = thr_q;
    assign bus.score_left  = sl_q;
    assign bus.score_right = sr_q;
    assign bus.point_pulse = pulse_q;
    assign bus.game_over   = over_q;
endmodule

// File: tb/tb_ball_controller.sv
// Directed bench for ball_controller: ball and paddle coordinates are driven directly;
// scored points are checked by a pulse-driven monitor against a queue of expected scores.
module tb_ball_controller;
    logic clock;
    logic reset;

    ball_if #(.CWIDTH(9)) bus ();

    ball_controller #(.SERVE_DELAY(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct {
        logic [3:0] left;
        logic [3:0] right;
    } point_t;

    point_t point_q[$];
    int     checks   = 0;
    int     failures = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ball(input int x, input int y);
        bus.ball_x = 10'(x);
        bus.ball_y = 10'(y);
    endtask

    task automatic neutral();
        set_ball(300, 200);
    endtask

    // Counts ticks until move_active rises, bounded so a stuck DUT still reaches the summary.
    task automatic wait_play(output int n);
        n = 0;
        while (!bus.move_active && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Scoreboard monitor: each point strobe consumes one expected score pair.
    always @(negedge clock) begin
        if (!reset && bus.point_pulse) begin
            if (point_q.size() == 0) begin
                check("point_unexpected", 64'(point_q.size()), 64'd1);
            end else begin
                point_t p;
                p = point_q.pop_front();
                check("point_score_left", 64'(bus.score_left), 64'(p.left));
                check("point_score_right", 64'(bus.score_right), 64'(p.right));
            end
        end
    end

    initial begin
        int        n;
        logic      exp_x;
        logic      exp_y;
        int        exp_thr;

        reset              = 1'b1;
        bus.start          = 1'b0;
        bus.left_paddle_y  = 10'd80;
        bus.right_paddle_y = 10'd100;
        neutral();
        #12;
        check("rst_move_active", 64'(bus.move_active), 64'd0);
        check("rst_x_direction", 64'(bus.x_direction), 64'd1);
        check("rst_y_direction", 64'(bus.y_direction), 64'd1);
        check("rst_threshold", bus.threshold, 64'd200000);
        check("rst_scores", 64'({bus.score_left, bus.score_right}), 64'd0);
        check("rst_pulse_over", 64'({bus.point_pulse, bus.game_over}), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("idle_move_active", 64'(bus.move_active), 64'd0);

        // Start pulse: move_active rises on the 11th edge counting the one that samples start.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("serve_move_active_low", 64'(bus.move_active), 64'd0);
        wait_play(n);
        check("start_to_move_active", 64'(n + 1), 64'd11);

        // Bottom wall flips once, start is ignored in PLAY, top wall flips back.
        set_ball(300, 479);
        tick();
        check("bottom_wall", 64'(bus.y_direction), 64'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("bottom_wall_once", 64'(bus.y_direction), 64'd0);
        check("start_ignored_play", 64'(bus.move_active), 64'd1);
        set_ball(300, 0);
        tick();
        check("top_wall", 64'(bus.y_direction), 64'd1);
        neutral();

        // Right paddle hit at its top row, then the left paddle hit from the test plan.
        exp_thr = 200000;
        set_ball(638, 100);
        tick();
        exp_thr = 190000;
        check("right_hit_xdir", 64'(bus.x_direction), 64'd0);
        check("right_hit_thr", bus.threshold, 64'(exp_thr));
        neutral();
        set_ball(1, 100);
        tick();
        exp_thr = 180000;
        check("left_hit_xdir", 64'(bus.x_direction), 64'd1);
        check("left_hit_thr", bus.threshold, 64'(exp_thr));
        neutral();

        // Alternate hits until the threshold sits on its 50000 floor; left hits use the paddle's last row.
        exp_x = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (exp_x) set_ball(638, 100);
            else       set_ball(1, 143);
            tick();
            exp_x   = !exp_x;
            exp_thr = (exp_thr - 10000 < 50000) ? 50000 : exp_thr - 10000;
            check("rally_xdir", 64'(bus.x_direction), 64'(exp_x));
            check("rally_thr", bus.threshold, 64'(exp_thr));
            neutral();
        end
        check("thr_floor", bus.threshold, 64'd50000);

        // Corner: right paddle column and bottom wall together flip both directions.
        bus.right_paddle_y = 10'd420;
        set_ball(638, 479);
        tick();
        check("corner_xdir", 64'(bus.x_direction), 64'd0);
        check("corner_ydir", 64'(bus.y_direction), 64'd0);
        neutral();

        // One row below the left paddle is a miss; then the ball reaches x=0.
        set_ball(1, 144);
        tick();
        check("miss_edge_xdir", 64'(bus.x_direction), 64'd0);
        set_ball(0, 200);
        point_q.push_back('{left: 4'd0, right: 4'd1});
        tick();
        check("scored_move_active", 64'(bus.move_active), 64'd0);
        neutral();
        tick();
        check("after_point_pulse", 64'(bus.point_pulse), 64'd0);
        check("after_point_thr", bus.threshold, 64'd200000);
        check("after_point_xdir", 64'(bus.x_direction), 64'd0);
        check("after_point_ydir", 64'(bus.y_direction), 64'd1);
        wait_play(n);
        check("reserve_latency", 64'(n), 64'd10);

        // Right player scores up to 7; the ball sits on a wall each time to test score priority.
        exp_y = 1'b1;
        for (int k = 2; k <= 7; k++) begin
            set_ball(0, exp_y ? 479 : 0);
            point_q.push_back('{left: 4'd0, right: 4'(k)});
            tick();
            neutral();
            tick();
            exp_y = !exp_y;
            check("score_priority_ydir", 64'(bus.y_direction), 64'(exp_y));
            if (k < 7) begin
                wait_play(n);
                check("reserve_latency", 64'(n), 64'd10);
            end
        end
        check("over_game_over", 64'(bus.game_over), 64'd1);
        check("over_move_active", 64'(bus.move_active), 64'd0);
        check("over_score_right", 64'(bus.score_right), 64'd7);
        tick();
        tick();
        check("over_held_score", 64'(bus.score_right), 64'd7);
        check("over_held_flag", 64'(bus.game_over), 64'd1);

        // Restart from OVER.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart_scores", 64'({bus.score_left, bus.score_right}), 64'd0);
        check("restart_game_over", 64'(bus.game_over), 64'd0);
        check("restart_move_active", 64'(bus.move_active), 64'd0);
        wait_play(n);
        check("restart_latency", 64'(n), 64'd10);

        // Left point after a left-paddle return; serve then heads toward the right player.
        set_ball(1, 100);
        tick();
        check("left_hit2_thr", bus.threshold, 64'd190000);
        set_ball(639, 200);
        point_q.push_back('{left: 4'd1, right: 4'd0});
        tick();
        neutral();
        tick();
        check("left_point_xdir", 64'(bus.x_direction), 64'd1);
        check("left_point_thr", bus.threshold, 64'd200000);
        wait_play(n);
        check("reserve_latency", 64'(n), 64'd10);
        bus.right_paddle_y = 10'd100;
        set_ball(638, 100);
        tick();
        check("right_hit2_thr", bus.threshold, 64'd190000);
        neutral();

        // Reset mid-rally clears outputs in the same time step, not at the next edge.
        #2;
        reset = 1'b1;
        #1;
        check("midrst_move_active", 64'(bus.move_active), 64'd0);
        check("midrst_threshold", bus.threshold, 64'd200000);
        check("midrst_score_left", 64'(bus.score_left), 64'd0);
        check("midrst_dirs", 64'({bus.x_direction, bus.y_direction}), 64'd3);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_idle", 64'(bus.move_active), 64'd0);
        check("post_rst_game_over", 64'(bus.game_over), 64'd0);

        check("point_queue_drained", 64'(point_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ball_controller.md
Name: ball_controller

Overview:
- Sequences the two per-axis ball movers (x and y) for the pong game: serve, wall and paddle bounces, speed-up, scoring and game over.
- Drives each mover's active, direction and threshold inputs and reads back its coordinate.
- Sits between the movers, the paddle position logic and the score display.

Parameters:
- CWIDTH, 9, MSB index of coordinates; coordinate buses are [CWIDTH:0].
- SCREEN_W, 640, playfield width in pixels.
- SCREEN_H, 480, playfield height in pixels.
- PADDLE_H, 64, paddle height in pixels.
- BASE_THRESHOLD, 200000, wait-cycle threshold at serve.
- THRESHOLD_STEP, 10000, threshold decrement per paddle hit.
- MIN_THRESHOLD, 50000, threshold floor.
- SERVE_DELAY, 50000000, cycles held in SERVE before release.
- WIN_SCORE, 7, points that end the game.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; begins a game from IDLE or OVER.
- ball_x  in  CWIDTH+1  x coordinate from the x mover.
- ball_y  in  CWIDTH+1  y coordinate from the y mover.
- left_paddle_y  in  CWIDTH+1  top row of the left paddle.
- right_paddle_y  in  CWIDTH+1  top row of the right paddle.
- move_active  out  1  enable to both movers.
- x_direction  out  1  1 = +x (right).
- y_direction  out  1  1 = +y (down).
- threshold  out  64  wait-cycle threshold to both movers.
- score_left  out  4  left player points.
- score_right  out  4  right player points.
- point_pulse  out  1  one-cycle strobe on each point.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset (async, immediate): state=IDLE; move_active=0; x_direction=1; y_direction=1; threshold=BASE_THRESHOLD; scores=0; point_pulse=0; game_over=0; serve counter=0.
- Reset mid-rally: movers see move_active=0 in the same cycle, which clears their coordinates.
- All outputs are registered; state updates on posedge clock.
- IDLE: move_active=0. start=1 -> SERVE next cycle, scores cleared, threshold=BASE_THRESHOLD.
- SERVE: move_active=0; counter increments each cycle. When counter==SERVE_DELAY-1 -> PLAY and counter clears. Exactly SERVE_DELAY cycles are spent in SERVE.
- PLAY: move_active=1. Each cycle, evaluate ball_x/ball_y:
  - Top wall: ball_y==0 and y_direction==0 -> y_direction<=1.
  - Bottom wall: ball_y==SCREEN_H-1 and y_direction==1 -> y_direction<=0.
  - Left paddle column: ball_x==1, x_direction==0, and left_paddle_y <= ball_y <= left_paddle_y+PADDLE_H-1 -> x_direction<=1 and speed-up.
  - Right paddle column: ball_x==SCREEN_W-2, x_direction==1, same range test with right_paddle_y -> x_direction<=0 and speed-up.
  - Paddle range arithmetic is done at CWIDTH+2 bits so paddle_y+PADDLE_H cannot wrap.
  - Speed-up: threshold <= max(threshold-THRESHOLD_STEP, MIN_THRESHOLD). Compute without underflow.
  - Right scores: ball_x==0 and x_direction==0 -> score_right+1, point_pulse=1, state -> SCORED.
  - Left scores: ball_x==SCREEN_W-1 and x_direction==1 -> score_left+1, point_pulse=1, state -> SCORED.
  - Each condition includes the direction bit, so every flip fires exactly once per contact.
  - Corner hits (wall and paddle in the same cycle) flip both directions in that cycle.
  - A score takes priority over a wall flip in the same cycle.
- SCORED (1 cycle): move_active=0; threshold<=BASE_THRESHOLD; x_direction set toward the player who conceded; y_direction toggled.
  - If the incremented score == WIN_SCORE -> OVER.
  - Otherwise -> SERVE.
- OVER: game_over=1; move_active=0; scores held. start=1 -> SERVE with scores cleared.
- Scores saturate at WIN_SCORE and never wrap.
- start is ignored in SERVE, PLAY and SCORED.

Test Plan:
- Reset asserted mid-PLAY -> within the same cycle move_active=0, scores=0, threshold=200000; state IDLE after release.
- start pulse from IDLE -> move_active rises exactly SERVE_DELAY+1 cycles later (set SERVE_DELAY=10 in bench: cycle 11).
- Left paddle hit: force ball_x=1, ball_y=100, left_paddle_y=80, x_direction=0 -> x_direction=1 next cycle, threshold=190000. Repeated hits -> threshold floors at 50000.
- Paddle miss: ball_y=200, left_paddle_y=80, ball reaches x=0 -> score_right=1, one-cycle point_pulse, threshold back to 200000, x_direction=0, then SERVE.
- Corner: ball_x=SCREEN_W-2=638, ball_y=479, right paddle covering row 479, both directions=1 -> both flip to 0 in one cycle.
- Right player reaches 7 -> game_over=1, move_active=0. start -> scores 0, SERVE entered.
